// File: rtl/wb_commit.sv
// -----------------------------------------------------------------------------
// wb_commit -- write-back / commit stage.
//
// This stage takes the instruction held in the EX/WB buffer and turns it into
// a register-file write and, for a taken branch or jump, a one-cycle PC
// redirect pulse. It then squashes the next FLUSH_DEPTH younger instructions.
// Every output is registered, so each result appears one clock after its inputs.
//
// Parameters
//   FLUSH_DEPTH  number of squash cycles after a redirect (legal range 1..7)
//
// Optional feature (compile-time macro)
//   WB_RETIRE_COUNT_EN  when defined, out_retired counts live instructions and
//                       saturates at 0xFFFFFFFF. When undefined, out_retired is
//                       tied to 0 and no counter logic is built.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   in_valid            the EX/WB stage holds an instruction this cycle
//   in_ctrl_*           write-back control bits (regwrt, branch, btype, jump,
//                       memtoreg, neg, zero)
//   in_memdata          load data
//   in_aluresult        ALU result
//   in_rd               destination register (0..63, none is hardwired)
//   in_target           branch/jump target PC
//   out_rf_we/waddr/wdata  register-file write port
//   out_redirect        one-cycle PC redirect pulse
//   out_redirect_pc     redirect target; keeps its last value between pulses
//   out_flush           high while younger instructions are squashed
//   out_retired         retired-instruction count
//   dbg_state           FSM state (0 = RUN, 1 = SQUASH)
//   dbg_cnt             squash cycles remaining
//
// Handshake: there is no backpressure. An instruction is consumed in every
// cycle that in_valid is high. It is "live" only while the FSM is in RUN.
// Otherwise it is dropped with no write, no retire and no redirect.
// -----------------------------------------------------------------------------
module wb_commit #(
  parameter int FLUSH_DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_ctrl_regwrt,
  input  logic        in_ctrl_branch,
  input  logic        in_ctrl_btype,
  input  logic        in_ctrl_jump,
  input  logic        in_ctrl_memtoreg,
  input  logic        in_ctrl_neg,
  input  logic        in_ctrl_zero,
  input  logic [31:0] in_memdata,
  input  logic [31:0] in_aluresult,
  input  logic [5:0]  in_rd,
  input  logic [31:0] in_target,
  output logic        out_rf_we,
  output logic [5:0]  out_rf_waddr,
  output logic [31:0] out_rf_wdata,
  output logic        out_redirect,
  output logic [31:0] out_redirect_pc,
  output logic        out_flush,
  output logic [31:0] out_retired,
  output logic        dbg_state,
  output logic [2:0]  dbg_cnt
);

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        redirect_nxt;
  logic        flush_nxt;
  logic        live;
  logic        taken;
  logic [31:0] wdata_sel;

  assign live  = in_valid && (state == RUN);
  assign taken = in_ctrl_jump ||
                 (in_ctrl_branch && ((!in_ctrl_btype && in_ctrl_zero) ||
                                     ( in_ctrl_btype && in_ctrl_neg)));
  assign wdata_sel = in_ctrl_memtoreg ? in_memdata : in_aluresult;

  // Next-state logic. The redirect and the first flush cycle are produced in
  // the same output cycle. The last flush cycle is the one in which the
  // counter steps from 1 to 0. That makes out_flush high for FLUSH_DEPTH
  // cycles, and it also squashes FLUSH_DEPTH younger instructions.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    redirect_nxt = 1'b0;
    flush_nxt    = 1'b0;
    case (state)
      RUN: begin
        if (live && taken) begin
          state_nxt    = SQUASH;
          cnt_nxt      = 3'(FLUSH_DEPTH);
          redirect_nxt = 1'b1;
          flush_nxt    = 1'b1;
        end
      end
      SQUASH: begin
        // Taken branches seen here are ignored; the counter is never reloaded.
        cnt_nxt = cnt - 3'd1;
        if (cnt <= 3'd1) begin
          state_nxt = RUN;
          cnt_nxt   = 3'd0;
        end else begin
          flush_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Registered outputs. The write address and data hold their value when
  // there is no write, and the redirect PC holds its value between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_rf_we       <= 1'b0;
      out_rf_waddr    <= 6'd0;
      out_rf_wdata    <= 32'd0;
      out_redirect    <= 1'b0;
      out_redirect_pc <= 32'd0;
      out_flush       <= 1'b0;
    end else begin
      out_rf_we    <= live && in_ctrl_regwrt;
      out_redirect <= redirect_nxt;
      out_flush    <= flush_nxt;
      if (live && in_ctrl_regwrt) begin
        out_rf_waddr <= in_rd;
        out_rf_wdata <= wdata_sel;
      end
      if (redirect_nxt) begin
        out_redirect_pc <= in_target;
      end
    end
  end

`ifdef WB_RETIRE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_retired <= 32'd0;
    end else if (live && (out_retired != 32'hFFFF_FFFF)) begin
      out_retired <= out_retired + 32'd1;
    end
  end
`else
  assign out_retired = 32'd0;
`endif

  assign dbg_state = state;
  assign dbg_cnt   = cnt;

endmodule

// File: tb/tb_wb_commit.sv
// -----------------------------------------------------------------------------
// tb_wb_commit -- self-checking bench for wb_commit (FLUSH_DEPTH = 3).
// Table of single-cycle vectors in RUN, then hand-written multi-cycle
// sequences: branch squash, link jump with ignored jump in squash, reset
// mid-squash, and retire counting.
// -----------------------------------------------------------------------------
module tb_wb_commit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ctrl_regwrt, in_ctrl_branch, in_ctrl_btype, in_ctrl_jump;
  logic        in_ctrl_memtoreg, in_ctrl_neg, in_ctrl_zero;
  logic [31:0] in_memdata, in_aluresult, in_target;
  logic [5:0]  in_rd;
  logic        out_rf_we, out_redirect, out_flush;
  logic [5:0]  out_rf_waddr;
  logic [31:0] out_rf_wdata, out_redirect_pc, out_retired;
  logic        dbg_state;
  logic [2:0]  dbg_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  wb_commit #(.FLUSH_DEPTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ctrl_regwrt(in_ctrl_regwrt), .in_ctrl_branch(in_ctrl_branch),
    .in_ctrl_btype(in_ctrl_btype), .in_ctrl_jump(in_ctrl_jump),
    .in_ctrl_memtoreg(in_ctrl_memtoreg), .in_ctrl_neg(in_ctrl_neg),
    .in_ctrl_zero(in_ctrl_zero), .in_memdata(in_memdata),
    .in_aluresult(in_aluresult), .in_rd(in_rd), .in_target(in_target),
    .out_rf_we(out_rf_we), .out_rf_waddr(out_rf_waddr),
    .out_rf_wdata(out_rf_wdata), .out_redirect(out_redirect),
    .out_redirect_pc(out_redirect_pc), .out_flush(out_flush),
    .out_retired(out_retired), .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic        valid, regwrt, branch, btype, jump, memtoreg, neg, zero;
    logic [31:0] memdata, alu;
    logic [5:0]  rd;
    logic [31:0] target;
    logic        e_we;
    logic [5:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_red, e_flush;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[10];

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic v, input logic rw, input logic br,
                        input logic bt, input logic jp, input logic m2r,
                        input logic ng, input logic zr, input logic [31:0] md,
                        input logic [31:0] alu, input logic [5:0] rd,
                        input logic [31:0] tgt);
    in_valid         = v;
    in_ctrl_regwrt   = rw;
    in_ctrl_branch   = br;
    in_ctrl_btype    = bt;
    in_ctrl_jump     = jp;
    in_ctrl_memtoreg = m2r;
    in_ctrl_neg      = ng;
    in_ctrl_zero     = zr;
    in_memdata       = md;
    in_aluresult     = alu;
    in_rd            = rd;
    in_target        = tgt;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6'd0, 32'h0);
  endtask

  task automatic alu_op(input logic [5:0] rd, input logic [31:0] alu);
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, alu, rd, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".we"},       32'(out_rf_we),    32'h0);
    check({tag, ".waddr"},    32'(out_rf_waddr), 32'h0);
    check({tag, ".wdata"},    out_rf_wdata,      32'h0);
    check({tag, ".redirect"}, 32'(out_redirect), 32'h0);
    check({tag, ".pc"},       out_redirect_pc,   32'h0);
    check({tag, ".flush"},    32'(out_flush),    32'h0);
    check({tag, ".retired"},  out_retired,       32'h0);
  endtask

  logic       exp_flush_seq[4];
  logic       exp_we_seq[4];
  logic [31:0] exp_retired;

  initial begin
    rst_n = 1'b0;
    idle();

    // Columns: v rw br bt jp m2r ng zr memdata alu rd target | we waddr wdata red flush pc
    vecs[0] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h0000002A, 6'd5,  32'h0,   1'b1, 6'd5,  32'h0000002A, 1'b0,1'b0, 32'h0};
    vecs[1] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 32'hDEADBEEF, 32'h00000010, 6'd7,  32'h0,   1'b1, 6'd7,  32'hDEADBEEF, 1'b0,1'b0, 32'h0};
    vecs[2] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h00000001, 6'd9,  32'h0,   1'b0, 6'd7,  32'hDEADBEEF, 1'b0,1'b0, 32'h0};
    vecs[3] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h00000002, 6'd3,  32'h0,   1'b0, 6'd7,  32'hDEADBEEF, 1'b0,1'b0, 32'h0};
    vecs[4] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h0,        6'd0,  32'h100, 1'b0, 6'd7,  32'hDEADBEEF, 1'b0,1'b0, 32'h0};
    vecs[5] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 32'h0,        32'h0,        6'd0,  32'h104, 1'b0, 6'd7,  32'hDEADBEEF, 1'b0,1'b0, 32'h0};
    vecs[6] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 32'h0,        32'h0,        6'd0,  32'h108, 1'b0, 6'd7,  32'hDEADBEEF, 1'b0,1'b0, 32'h0};
    vecs[7] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 32'h0,        32'hFFFF0000, 6'd63, 32'h10C, 1'b1, 6'd63, 32'hFFFF0000, 1'b0,1'b0, 32'h0};
    vecs[8] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h00000011, 6'd0,  32'h0,   1'b1, 6'd0,  32'h00000011, 1'b0,1'b0, 32'h0};
    vecs[9] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 32'h0,        32'h0,        6'd0,  32'h200, 1'b0, 6'd0,  32'h00000011, 1'b0,1'b0, 32'h0};

    // Reset state.
    #2;
    check_all_zero("reset");
    check("reset.state", 32'(dbg_state), 32'h0);
    check("reset.cnt",   32'(dbg_cnt),   32'h0);
    do_reset();

    // Table-driven single-cycle vectors in RUN.
    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].valid, vecs[i].regwrt, vecs[i].branch, vecs[i].btype,
             vecs[i].jump, vecs[i].memtoreg, vecs[i].neg, vecs[i].zero,
             vecs[i].memdata, vecs[i].alu, vecs[i].rd, vecs[i].target);
      tick();
      check($sformatf("vec%0d.we", i),       32'(out_rf_we),    32'(vecs[i].e_we));
      check($sformatf("vec%0d.waddr", i),    32'(out_rf_waddr), 32'(vecs[i].e_waddr));
      check($sformatf("vec%0d.wdata", i),    out_rf_wdata,      vecs[i].e_wdata);
      check($sformatf("vec%0d.redirect", i), 32'(out_redirect), 32'(vecs[i].e_red));
      check($sformatf("vec%0d.flush", i),    32'(out_flush),    32'(vecs[i].e_flush));
      check($sformatf("vec%0d.pc", i),       out_redirect_pc,   vecs[i].e_pc);
    end

    // BRN taken (neg=1), then three live writes are squashed and the fourth
    // one commits.
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 6'd0, 32'h40);
    tick();
    check("brn.redirect", 32'(out_redirect), 32'h1);
    check("brn.pc",       out_redirect_pc,   32'h40);
    check("brn.flush",    32'(out_flush),    32'h1);
    check("brn.we",       32'(out_rf_we),    32'h0);
    check("brn.state",    32'(dbg_state),    32'h1);
    check("brn.cnt",      32'(dbg_cnt),      32'h3);
    exp_flush_seq = '{1'b1, 1'b1, 1'b0, 1'b0};
    exp_we_seq    = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      alu_op(6'(10 + k), 32'(256 + k));
      tick();
      check($sformatf("brn_seq%0d.flush", k),    32'(out_flush),    32'(exp_flush_seq[k]));
      check($sformatf("brn_seq%0d.we", k),       32'(out_rf_we),    32'(exp_we_seq[k]));
      check($sformatf("brn_seq%0d.redirect", k), 32'(out_redirect), 32'h0);
      check($sformatf("brn_seq%0d.pc", k),       out_redirect_pc,   32'h40);
    end
    check("brn_post.waddr", 32'(out_rf_waddr), 32'd13);
    check("brn_post.wdata", out_rf_wdata,      32'd259);

    // Link jump writes and redirects in the same cycle. Jumps presented
    // during the squash are ignored, and the flush ends on schedule.
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h44, 6'd31, 32'h80);
    tick();
    check("link.redirect", 32'(out_redirect), 32'h1);
    check("link.pc",       out_redirect_pc,   32'h80);
    check("link.we",       32'(out_rf_we),    32'h1);
    check("link.waddr",    32'(out_rf_waddr), 32'd31);
    check("link.wdata",    out_rf_wdata,      32'h44);
    check("link.flush",    32'(out_flush),    32'h1);
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1, 6'd1, 32'h200);
    tick();
    check("sqjmp1.redirect", 32'(out_redirect), 32'h0);
    check("sqjmp1.flush",    32'(out_flush),    32'h1);
    check("sqjmp1.we",       32'(out_rf_we),    32'h0);
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 6'd0, 32'h300);
    tick();
    check("sqjmp2.redirect", 32'(out_redirect), 32'h0);
    check("sqjmp2.flush",    32'(out_flush),    32'h1);
    check("sqjmp2.pc",       out_redirect_pc,   32'h80);
    idle();
    tick();
    check("sqend.flush", 32'(out_flush), 32'h0);
    check("sqend.state", 32'(dbg_state), 32'h0);
    alu_op(6'd2, 32'h5);
    tick();
    check("after_sq.we",    32'(out_rf_we),    32'h1);
    check("after_sq.waddr", 32'(out_rf_waddr), 32'd2);
    check("after_sq.flush", 32'(out_flush),    32'h0);
    check("after_sq.redirect", 32'(out_redirect), 32'h0);

    // Reset during the second squash cycle clears everything at once.
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h9, 6'd4, 32'h1234);
    tick();
    check("rs.redirect", 32'(out_redirect), 32'h1);
    idle();
    in_valid = 1'b1;
    tick();
    check("rs.flush2", 32'(out_flush), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midsq_reset");
    check("midsq_reset.state", 32'(dbg_state), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    alu_op(6'd6, 32'h77);
    tick();
    check("post_rst.we",    32'(out_rf_we),    32'h1);
    check("post_rst.waddr", 32'(out_rf_waddr), 32'd6);
    check("post_rst.wdata", out_rf_wdata,      32'h77);
    check("post_rst.flush", 32'(out_flush),    32'h0);

    // Retire count: 10 presented, slot 2 is a taken BRZ that squashes slots
    // 3..5. Seven instructions are live.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k == 2)
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 6'd0, 32'h50);
      else
        alu_op(6'(20 + k), 32'(k));
      tick();
    end
    idle();
    tick();
`ifdef WB_RETIRE_COUNT_EN
    exp_retired = 32'd7;
`else
    exp_retired = 32'd0;
`endif
    check("retired", out_retired, exp_retired);
    check("retired.last_waddr", 32'(out_rf_waddr), 32'd29);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_commit.md
WB_COMMIT -- requirements
Module: wb_commit

Interface
REQ-001 Parameter FLUSH_DEPTH, default 3, number of squash cycles after a redirect; legal range 1..7.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  EX/WB stage holds a live instruction this cycle.
REQ-006 in_ctrl_regwrt, in_ctrl_branch, in_ctrl_btype, in_ctrl_jump, in_ctrl_memtoreg, in_ctrl_neg, in_ctrl_zero  input  1 each  WB control from the EX/WB buffer.
REQ-007 in_memdata  input  32  load data; in_aluresult  input  32  ALU result; in_rd  input  6  destination register.
REQ-008 in_target  input  32  branch/jump target PC.
REQ-009 out_rf_we  output  1  register-file write enable; out_rf_waddr  output  6; out_rf_wdata  output  32.
REQ-010 out_redirect  output  1  one-cycle PC redirect pulse; out_redirect_pc  output  32  redirect target.
REQ-011 out_flush  output  1  high while younger instructions are squashed.
REQ-012 out_retired  output  32  retired-instruction count (see Configuration).

Function
REQ-013 All outputs SHALL be registered; one cycle of latency from inputs to outputs.
REQ-014 An instruction is "live" when in_valid=1 and the FSM is in RUN; otherwise it is squashed.
REQ-015 Write data SHALL be in_memdata when in_ctrl_memtoreg=1, else in_aluresult.
REQ-016 out_rf_we SHALL be 1 next cycle only for a live instruction with in_ctrl_regwrt=1; waddr/wdata SHALL be loaded with in_rd and the selected data.
REQ-017 Any rd value 0..63 SHALL be writable; no register is hardwired.
REQ-018 Taken = in_ctrl_jump OR (in_ctrl_branch AND ((in_ctrl_btype=0 AND in_ctrl_zero) OR (in_ctrl_btype=1 AND in_ctrl_neg))).
REQ-019 FSM states: RUN, SQUASH; a 3-bit down-counter holds remaining squash cycles.
REQ-020 RUN, live and taken: next cycle out_redirect=1 for exactly one cycle, out_redirect_pc=in_target, state goes to SQUASH, counter loads FLUSH_DEPTH.
REQ-021 SQUASH: out_flush=1, every instruction presented is squashed (no write, no retire, no redirect), counter decrements each cycle; exiting to RUN when the counter goes from 1 to 0.
REQ-022 out_flush SHALL be high for exactly FLUSH_DEPTH cycles, starting the cycle out_redirect is high.
REQ-023 A taken branch presented during SQUASH SHALL be ignored; it does not restart the counter.
REQ-024 A live taken instruction with in_ctrl_regwrt=1 (link) SHALL perform both its register write and the redirect in the same output cycle.
REQ-025 out_redirect_pc SHALL hold its last value when out_redirect=0.
REQ-026 in_valid=0 in RUN: out_rf_we=0, no state change.

Reset
REQ-027 rst_n low SHALL immediately clear out_rf_we, out_redirect, out_flush, out_rf_waddr, out_rf_wdata, out_redirect_pc, out_retired to 0 and set the state to RUN with counter 0.
REQ-028 Reset asserted mid-SQUASH SHALL abort the squash; the first cycle after deassertion is RUN.
REQ-029 Reset deassertion SHALL take effect on the following posedge only; there SHALL be no output glitch beyond the clear.

Configuration
REQ-030 Macro WB_RETIRE_COUNT_EN: when defined, out_retired SHALL increment by 1 on each live instruction, saturate at 0xFFFFFFFF, and clear on reset.
REQ-031 Without WB_RETIRE_COUNT_EN, out_retired SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-032 Live add: regwrt=1, memtoreg=0, aluresult=0x0000002A, rd=5 -> next cycle we=1, waddr=5, wdata=0x2A, redirect=0.
REQ-033 Live load: memtoreg=1, memdata=0xDEADBEEF, aluresult=0x10 -> wdata=0xDEADBEEF.
REQ-034 BRN, neg=1, target=0x40, FLUSH_DEPTH=3, three more live regwrt instructions follow -> redirect pulse 1 cycle with pc 0x40, flush high 3 cycles, no writes for those 3, 4th instruction writes.
REQ-035 BRZ with zero=0 -> no redirect, no flush; jump during SQUASH -> ignored, flush still ends on schedule.
REQ-036 rst_n low during 2nd squash cycle -> all outputs 0 at once; after release, next live write commits normally.
REQ-037 With WB_RETIRE_COUNT_EN, 10 live instructions including one taken branch squashing 3 -> out_retired=7 after the 3 squashed slots are excluded (10 presented, 3 squashed); without the macro -> out_retired stays 0.
